// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : arcade_input_mapper
//  Purpose  : PS/2 key latching, joystick merge, rotation, autofire and coin
//             pulse shaping for 1-4 player arcade cores.
//  Revision : 1.0 - initial release
// ============================================================================
module arcade_input_mapper #(
    parameter int          PLAYERS      = 2,
    parameter logic [15:0] COIN_PULSE   = 16'd60000,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [10:0]             ps2_key,
    input  logic [16*PLAYERS-1:0]   joy_in,
    input  logic                    rotate,
    input  logic [PLAYERS-1:0]      autofire_en,
    input  logic                    coin_on_start,
    output logic [PLAYERS-1:0]      up,
    output logic [PLAYERS-1:0]      down,
    output logic [PLAYERS-1:0]      left,
    output logic [PLAYERS-1:0]      right,
    output logic [PLAYERS-1:0]      fire,
    output logic [1:0]              start,
    output logic [1:0]              coin,
    output logic                    test
);

    localparam bit c_has_p1 = (PLAYERS >= 2);

    typedef enum logic [1:0] {
        AF_IDLE = 2'd0,
        AF_ON   = 2'd1,
        AF_OFF  = 2'd2
    } af_state_t;

    typedef enum logic [1:0] {
        CN_IDLE  = 2'd0,
        CN_PULSE = 2'd1,
        CN_HOLD  = 2'd2
    } coin_state_t;

    // ------------------------------------------------------------------
    // Keyboard event detection and key latches
    // ------------------------------------------------------------------
    logic       r_old_tgl;
    logic [1:0] r_kb_up;
    logic [1:0] r_kb_down;
    logic [1:0] r_kb_left;
    logic [1:0] r_kb_right;
    logic       r_kb_space;
    logic       r_kb_ctrl;
    logic       r_kb_fire1;
    logic       r_kb_start1a;
    logic       r_kb_start1b;
    logic       r_kb_start2a;
    logic       r_kb_start2b;
    logic       r_kb_coin1;
    logic       r_kb_coin2;
    logic       r_kb_test;

    logic       w_evt;
    logic       w_prs;
    logic       w_ext;
    logic [7:0] w_code;

    assign w_evt  = ps2_key[10] ^ r_old_tgl;
    assign w_prs  = ps2_key[9];
    assign w_ext  = ps2_key[8];
    assign w_code = ps2_key[7:0];

    always_ff @(posedge clk_sys) begin
        // Tracking the toggle even in reset keeps reset release event-free.
        r_old_tgl <= ps2_key[10];
        if (reset) begin
            r_kb_up      <= 2'b00;
            r_kb_down    <= 2'b00;
            r_kb_left    <= 2'b00;
            r_kb_right   <= 2'b00;
            r_kb_space   <= 1'b0;
            r_kb_ctrl    <= 1'b0;
            r_kb_fire1   <= 1'b0;
            r_kb_start1a <= 1'b0;
            r_kb_start1b <= 1'b0;
            r_kb_start2a <= 1'b0;
            r_kb_start2b <= 1'b0;
            r_kb_coin1   <= 1'b0;
            r_kb_coin2   <= 1'b0;
            r_kb_test    <= 1'b0;
        end else if (w_evt) begin
            case (w_code)
                8'h75: r_kb_up[0]    <= w_prs;
                8'h72: r_kb_down[0]  <= w_prs;
                8'h6B: r_kb_left[0]  <= w_prs;
                8'h74: r_kb_right[0] <= w_prs;
                8'h14: r_kb_ctrl     <= w_prs;
                8'h29: if (!w_ext) r_kb_space <= w_prs;
                8'h2D: if (!w_ext && c_has_p1) r_kb_up[1]    <= w_prs;
                8'h2B: if (!w_ext && c_has_p1) r_kb_down[1]  <= w_prs;
                8'h23: if (!w_ext && c_has_p1) r_kb_left[1]  <= w_prs;
                8'h34: if (!w_ext && c_has_p1) r_kb_right[1] <= w_prs;
                8'h1C: if (!w_ext && c_has_p1) r_kb_fire1    <= w_prs;
                8'h16: if (!w_ext) r_kb_start1a <= w_prs;
                8'h05: if (!w_ext) r_kb_start1b <= w_prs;
                8'h1E: if (!w_ext) r_kb_start2a <= w_prs;
                8'h06: if (!w_ext) r_kb_start2b <= w_prs;
                8'h2E: if (!w_ext) r_kb_coin1   <= w_prs;
                8'h36: if (!w_ext) r_kb_coin2   <= w_prs;
                8'h2C: if (!w_ext) r_kb_test    <= w_prs;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-player merge of keyboard and joystick
    // ------------------------------------------------------------------
    logic [PLAYERS-1:0] w_kb_up, w_kb_down, w_kb_left, w_kb_right, w_kb_fire;
    logic [PLAYERS-1:0] w_raw_up, w_raw_down, w_raw_left, w_raw_right, w_raw_fire;
    logic [PLAYERS-1:0] w_js_s1, w_js_s2, w_js_coin;
    logic [PLAYERS-1:0] w_joy_unused;

    genvar p;
    generate
        for (p = 0; p < PLAYERS; p++) begin : g_player
            logic [15:0] w_joy;
            assign w_joy = joy_in[16*p +: 16];

            if (p == 0) begin : g_kb0
                assign w_kb_up[p]    = r_kb_up[0];
                assign w_kb_down[p]  = r_kb_down[0];
                assign w_kb_left[p]  = r_kb_left[0];
                assign w_kb_right[p] = r_kb_right[0];
                assign w_kb_fire[p]  = r_kb_space | r_kb_ctrl;
            end else if (p == 1) begin : g_kb1
                assign w_kb_up[p]    = r_kb_up[1];
                assign w_kb_down[p]  = r_kb_down[1];
                assign w_kb_left[p]  = r_kb_left[1];
                assign w_kb_right[p] = r_kb_right[1];
                assign w_kb_fire[p]  = r_kb_fire1;
            end else begin : g_kbn
                assign w_kb_up[p]    = 1'b0;
                assign w_kb_down[p]  = 1'b0;
                assign w_kb_left[p]  = 1'b0;
                assign w_kb_right[p] = 1'b0;
                assign w_kb_fire[p]  = 1'b0;
            end

            assign w_raw_right[p]  = w_kb_right[p] | w_joy[0];
            assign w_raw_left[p]   = w_kb_left[p]  | w_joy[1];
            assign w_raw_down[p]   = w_kb_down[p]  | w_joy[2];
            assign w_raw_up[p]     = w_kb_up[p]    | w_joy[3];
            assign w_raw_fire[p]   = w_kb_fire[p]  | w_joy[4];
            assign w_js_s1[p]      = w_joy[5];
            assign w_js_s2[p]      = w_joy[6];
            assign w_js_coin[p]    = w_joy[7];
            assign w_joy_unused[p] = ^w_joy[15:8];
        end
    endgenerate

    logic [PLAYERS-1:0] w_rot_up, w_rot_down, w_rot_left, w_rot_right;
    logic               w_raw_start1, w_raw_start2;
    logic [1:0]         w_raw_coin;

    // Horizontal cabinets: the stick is turned a quarter, so remap directions.
    assign w_rot_up    = rotate ? w_raw_left  : w_raw_up;
    assign w_rot_down  = rotate ? w_raw_right : w_raw_down;
    assign w_rot_left  = rotate ? w_raw_down  : w_raw_left;
    assign w_rot_right = rotate ? w_raw_up    : w_raw_right;

    assign w_raw_start1  = r_kb_start1a | r_kb_start1b | (|w_js_s1);
    assign w_raw_start2  = r_kb_start2a | r_kb_start2b | (|w_js_s2);
    assign w_raw_coin[0] = r_kb_coin1 | (|w_js_coin) |
                           (coin_on_start & (w_raw_start1 | w_raw_start2));
    assign w_raw_coin[1] = r_kb_coin2;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            up    <= '0;
            down  <= '0;
            left  <= '0;
            right <= '0;
            start <= 2'b00;
            test  <= 1'b0;
        end else begin
            up    <= w_rot_up;
            down  <= w_rot_down;
            left  <= w_rot_left;
            right <= w_rot_right;
            start <= {w_raw_start2, w_raw_start1};
            test  <= r_kb_test;
        end
    end

    // ------------------------------------------------------------------
    // Autofire, one FSM per player
    // ------------------------------------------------------------------
    genvar a;
    generate
        for (a = 0; a < PLAYERS; a++) begin : g_af
            af_state_t   r_state, w_state_nx;
            logic [19:0] r_cnt, w_cnt_nx;
            logic        r_prev, r_fire, w_fire_nx;

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_state <= AF_IDLE;
                    r_cnt   <= 20'd0;
                    r_prev  <= 1'b0;
                    r_fire  <= 1'b0;
                end else begin
                    r_state <= w_state_nx;
                    r_cnt   <= w_cnt_nx;
                    r_prev  <= w_raw_fire[a];
                    r_fire  <= w_fire_nx;
                end
            end

            always_comb begin
                w_state_nx = r_state;
                w_cnt_nx   = r_cnt;
                w_fire_nx  = 1'b0;
                case (r_state)
                    AF_IDLE: begin
                        if (w_raw_fire[a] && !r_prev && autofire_en[a]) begin
                            w_state_nx = AF_ON;
                            w_cnt_nx   = 20'd0;
                        end
                    end
                    AF_ON, AF_OFF: begin
                        if (!w_raw_fire[a] || !autofire_en[a]) begin
                            w_state_nx = AF_IDLE;
                            w_cnt_nx   = 20'd0;
                        end else if (r_cnt == AUTOFIRE_DIV - 20'd1) begin
                            w_state_nx = (r_state == AF_ON) ? AF_OFF : AF_ON;
                            w_cnt_nx   = 20'd0;
                        end else begin
                            w_cnt_nx = r_cnt + 20'd1;
                        end
                    end
                    default: begin
                        w_state_nx = AF_IDLE;
                        w_cnt_nx   = 20'd0;
                    end
                endcase
                // Fire is registered from the next state so it rises with the FSM.
                w_fire_nx = (w_state_nx == AF_ON) ||
                            ((w_state_nx == AF_IDLE) && w_raw_fire[a] && !autofire_en[a]);
            end

            assign fire[a] = r_fire;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Coin pulse shaping, one FSM per slot
    // ------------------------------------------------------------------
    genvar s;
    generate
        for (s = 0; s < 2; s++) begin : g_coin
            coin_state_t r_state, w_state_nx;
            logic [15:0] r_cnt, w_cnt_nx;
            logic        r_prev, r_coin, w_coin_nx;

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_state <= CN_IDLE;
                    r_cnt   <= 16'd0;
                    r_prev  <= 1'b0;
                    r_coin  <= 1'b0;
                end else begin
                    r_state <= w_state_nx;
                    r_cnt   <= w_cnt_nx;
                    r_prev  <= w_raw_coin[s];
                    r_coin  <= w_coin_nx;
                end
            end

            always_comb begin
                w_state_nx = r_state;
                w_cnt_nx   = r_cnt;
                w_coin_nx  = 1'b0;
                case (r_state)
                    CN_IDLE: begin
                        if (w_raw_coin[s] && !r_prev) begin
                            w_state_nx = CN_PULSE;
                            w_cnt_nx   = 16'd0;
                        end
                    end
                    CN_PULSE: begin
                        if (r_cnt == COIN_PULSE - 16'd1) begin
                            w_state_nx = w_raw_coin[s] ? CN_HOLD : CN_IDLE;
                            w_cnt_nx   = 16'd0;
                        end else begin
                            w_cnt_nx = r_cnt + 16'd1;
                        end
                    end
                    CN_HOLD: begin
                        if (!w_raw_coin[s]) w_state_nx = CN_IDLE;
                    end
                    default: begin
                        w_state_nx = CN_IDLE;
                        w_cnt_nx   = 16'd0;
                    end
                endcase
                w_coin_nx = (w_state_nx == CN_PULSE);
            end

            assign coin[s] = r_coin;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arcade_input_mapper
//  Purpose  : Directed stimulus with a cycle-stamped expectation scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arcade_input_mapper;

    localparam logic [15:0] UP0 = 16'h0001, UP1 = 16'h0002, LEFT0 = 16'h0010,
                            LEFT1 = 16'h0020, RIGHT0 = 16'h0040, FIRE0 = 16'h0100,
                            FIRE1 = 16'h0200, ST1 = 16'h0400, ST2 = 16'h0800,
                            CN1 = 16'h1000, CN2 = 16'h2000, TST = 16'h4000,
                            ALL = 16'h7FFF;

    logic        clk_sys       = 1'b0;
    logic        reset         = 1'b1;
    logic [10:0] ps2_key       = 11'd0;
    logic [31:0] joy_in        = 32'd0;
    logic        rotate        = 1'b0;
    logic [1:0]  autofire_en   = 2'b00;
    logic        coin_on_start = 1'b0;
    logic [1:0]  up, down, left, right, fire, start, coin;
    logic        test;

    arcade_input_mapper #(
        .PLAYERS      (2),
        .COIN_PULSE   (16'd5),
        .AUTOFIRE_DIV (20'd3)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ps2_key       (ps2_key),
        .joy_in        (joy_in),
        .rotate        (rotate),
        .autofire_en   (autofire_en),
        .coin_on_start (coin_on_start),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .fire          (fire),
        .start         (start),
        .coin          (coin),
        .test          (test)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] mask;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] snap;
    assign snap = {1'b0, test, coin, start, fire, right, left, down, up};

    task automatic push_exp(input int d, input string nm, input logic [15:0] m,
                            input logic [15:0] v);
        exp_t e;
        e.cyc  = cyc + d;
        e.name = nm;
        e.mask = m;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic key(input logic prs, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], prs, ext, code};
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge clk_sys) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_vec++;
                if (sb[i].cyc != cyc || (snap & sb[i].mask) != sb[i].val) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: got %h required %h (mask %h)",
                             sb[i].name, cyc, snap & sb[i].mask, sb[i].val, sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        // Reset
        tick(2);
        push_exp(1, "reset_outs", ALL, 16'h0000);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Keyboard latching, 2-cycle latency
        key(1'b1, 1'b0, 8'h75);
        push_exp(1, "kb_latency", UP0 | UP1, 16'h0000);
        push_exp(2, "kb_up0", UP0 | UP1, UP0);
        tick(3);
        key(1'b0, 1'b0, 8'h75);
        push_exp(1, "kb_up0_hold", UP0, UP0);
        push_exp(2, "kb_up0_rel", UP0, 16'h0000);
        tick(3);
        key(1'b1, 1'b0, 8'h2D);
        push_exp(2, "kb_up1", UP0 | UP1, UP1);
        tick(3);
        key(1'b0, 1'b0, 8'h2D);
        push_exp(2, "kb_up1_rel", UP1, 16'h0000);
        tick(3);

        // Back-to-back events, extended arrow accepted
        key(1'b1, 1'b1, 8'h6B);
        tick(1);
        key(1'b1, 1'b0, 8'h23);
        push_exp(1, "b2b_first", LEFT0 | LEFT1, LEFT0);
        push_exp(2, "b2b_both", LEFT0 | LEFT1, LEFT0 | LEFT1);
        tick(3);
        key(1'b0, 1'b0, 8'h6B);
        tick(1);
        key(1'b0, 1'b0, 8'h23);
        push_exp(2, "b2b_rel", LEFT0 | LEFT1, 16'h0000);
        tick(3);

        // Extended bit: ignored on space, don't-care on ctrl
        key(1'b1, 1'b1, 8'h29);
        push_exp(2, "ext_space", FIRE0, 16'h0000);
        tick(3);
        key(1'b1, 1'b1, 8'h14);
        push_exp(2, "ext_ctrl", FIRE0, FIRE0);
        tick(3);
        key(1'b0, 1'b1, 8'h14);
        push_exp(2, "ctrl_rel", FIRE0, 16'h0000);
        tick(3);
        key(1'b1, 1'b0, 8'h2C);
        push_exp(2, "test_key", TST, TST);
        tick(3);
        key(1'b0, 1'b0, 8'h2C);
        push_exp(2, "test_rel", TST, 16'h0000);
        tick(3);
        key(1'b1, 1'b0, 8'h5A);
        push_exp(2, "unknown_code", ALL, 16'h0000);
        tick(3);
        key(1'b0, 1'b0, 8'h5A);
        tick(3);

        // Rotation, 1-cycle latency
        rotate = 1'b1;
        joy_in[3] = 1'b1;
        push_exp(1, "rot_up_to_right", UP0 | RIGHT0, RIGHT0);
        tick(2);
        rotate = 1'b0;
        push_exp(1, "rot_off", UP0 | RIGHT0, UP0);
        tick(2);
        joy_in[3]  = 1'b0;
        joy_in[1]  = 1'b1;
        joy_in[18] = 1'b1;
        rotate     = 1'b1;
        push_exp(1, "rot_left_down", ALL, UP0 | LEFT1);
        tick(2);
        rotate = 1'b0;
        joy_in = 32'd0;
        push_exp(1, "rot_clear", ALL, 16'h0000);
        tick(2);

        // Coin held 20 cycles, then a re-press released mid-pulse
        joy_in[7] = 1'b1;
        for (int d = 1; d <= 20; d++) push_exp(d, "coin_hold", CN1, (d <= 5) ? CN1 : 16'h0000);
        tick(20);
        joy_in[7] = 1'b0;
        push_exp(1, "coin_release", CN1, 16'h0000);
        tick(2);
        joy_in[23] = 1'b1;
        for (int d = 1; d <= 7; d++) push_exp(d, "coin_repress", CN1, (d <= 5) ? CN1 : 16'h0000);
        tick(2);
        joy_in[23] = 1'b0;
        tick(6);

        // Coin slot 2 from key 36
        key(1'b1, 1'b0, 8'h36);
        for (int d = 1; d <= 7; d++)
            push_exp(d, "coin2_key", CN1 | CN2, (d >= 2 && d <= 6) ? CN2 : 16'h0000);
        tick(8);
        key(1'b0, 1'b0, 8'h36);
        tick(3);

        // Coin on start
        coin_on_start = 1'b1;
        key(1'b1, 1'b0, 8'h16);
        push_exp(2, "start1_key", ST1 | ST2, ST1);
        for (int d = 1; d <= 7; d++)
            push_exp(d, "coin_on_start", CN1, (d >= 2 && d <= 6) ? CN1 : 16'h0000);
        tick(8);
        key(1'b0, 1'b0, 8'h16);
        push_exp(2, "start1_rel", ST1, 16'h0000);
        tick(3);
        coin_on_start = 1'b0;
        key(1'b1, 1'b0, 8'h05);
        push_exp(2, "start1_alt", ST1, ST1);
        for (int d = 1; d <= 7; d++) push_exp(d, "no_coin_on_start", CN1, 16'h0000);
        tick(8);
        key(1'b0, 1'b0, 8'h05);
        tick(3);
        joy_in[22] = 1'b1;
        push_exp(1, "start2_joy", ST1 | ST2, ST2);
        tick(2);
        joy_in[22] = 1'b0;
        tick(2);

        // Autofire player 0 from joystick
        autofire_en = 2'b01;
        joy_in[4] = 1'b1;
        for (int d = 1; d <= 14; d++)
            push_exp(d, "autofire0", FIRE0, ((((d - 1) / 3) % 2) == 0) ? FIRE0 : 16'h0000);
        tick(14);
        joy_in[4] = 1'b0;
        push_exp(1, "autofire0_rel", FIRE0, 16'h0000);
        tick(2);
        autofire_en = 2'b00;
        joy_in[4] = 1'b1;
        for (int d = 1; d <= 6; d++) push_exp(d, "steady_fire", FIRE0, FIRE0);
        tick(6);
        joy_in[4] = 1'b0;
        push_exp(1, "steady_rel", FIRE0, 16'h0000);
        tick(2);

        // Autofire player 1 from key 1C (one extra cycle of key latency)
        autofire_en = 2'b10;
        key(1'b1, 1'b0, 8'h1C);
        for (int d = 1; d <= 8; d++)
            push_exp(d, "autofire1", FIRE1,
                     (d >= 2 && (((d - 2) / 3) % 2) == 0) ? FIRE1 : 16'h0000);
        tick(8);
        key(1'b0, 1'b0, 8'h1C);
        push_exp(2, "autofire1_rel", FIRE1, 16'h0000);
        tick(3);
        autofire_en = 2'b00;

        // Reset during coin pulse cycle 2, key toggle swallowed by reset
        joy_in[7] = 1'b1;
        push_exp(1, "rst_pre1", CN1, CN1);
        push_exp(2, "rst_pre2", CN1, CN1);
        tick(2);
        reset = 1'b1;
        key(1'b1, 1'b0, 8'h75);
        push_exp(1, "rst_mid_pulse", ALL, 16'h0000);
        tick(1);
        reset = 1'b0;
        for (int d = 1; d <= 6; d++)
            push_exp(d, "rst_repulse", CN1 | UP0, (d <= 5) ? CN1 : 16'h0000);
        tick(8);
        joy_in[7] = 1'b0;
        key(1'b0, 1'b0, 8'h75);
        tick(3);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised control-input front end for the arcade cores: it decodes `ps2_key` events from `hps_io` into latched key states, merges them with per-player joystick words, applies orientation rotation and optional autofire, and generates width-controlled coin pulses. It sits between `hps_io` and the game core, replacing the per-core ad-hoc keyboard/joystick glue, and supports 1–4 players.

## Interface
- `PLAYERS`, 2: number of player channels, 1..4.
- `COIN_PULSE`, 16'd60000: coin output high time in `clk_sys` cycles, ≥1.
- `AUTOFIRE_DIV`, 20'd400000: autofire half-period in `clk_sys` cycles, ≥1.
- `clk_sys` in 1: the single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ps2_key` in 11: [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
- `joy_in` in 16*PLAYERS: joystick word per player; player p at [16p+15:16p]. Bits: 0 right, 1 left, 2 down, 3 up, 4 fire, 5 start1, 6 start2, 7 coin.
- `rotate` in 1: 1 = horizontal orientation, directions rotated.
- `autofire_en` in PLAYERS: per-player autofire enable.
- `coin_on_start` in 1: start requests also insert a coin.
- `up`, `down`, `left`, `right`, `fire` out PLAYERS each: per-player controls, bit p = player p.
- `start` out 2: start1, start2.
- `coin` out 2: coin slot 1, coin slot 2, pulse-shaped.
- `test` out 1: service/test key.

## Operation
- Event detect: `old_tgl` register; event when `ps2_key[10] != old_tgl`; `old_tgl <= ps2_key[10]` every cycle. On event, the matching latch loads `ps2_key[9]`; unknown codes ignored.
- Key map (extended bit don't-care on arrows and ctrl, required 0 elsewhere): player 0: 75 up, 72 down, 6B left, 74 right, 29 space / 14 ctrl fire. Player 1 (only if PLAYERS≥2): 2D up, 2B down, 23 left, 34 right, 1C fire. 16 or 05 start1; 1E or 06 start2; 2E coin1; 36 coin2; 2C test. Players 2–3 are joystick only.
- Merge: raw_dir[p] = key latch[p] | joy_in[p] bit; raw start1/start2 = keys | OR over all players of bits 5/6; raw coin1 = key 2E | OR of bit 7 | (coin_on_start & (raw start1 | raw start2)); raw coin2 = key 36.
- Rotation (rotate=1): up←left, down←right, left←down, right←up, applied after merge; rotate=0 passes through. rotate sampled every cycle, no glitch filtering.
- Autofire per player: FSM IDLE/ON/OFF with counter `af_cnt`. IDLE: raw fire rise with autofire_en[p] → ON, counter cleared. ON/OFF: counter reaches AUTOFIRE_DIV-1 → toggle state, counter cleared. Raw fire low or autofire_en[p] low → IDLE. `fire[p]` = 1 in ON; in IDLE = raw fire & ~autofire_en[p].
- Coin pulse per slot: FSM IDLE/PULSE/HOLD. IDLE: raw coin rise → PULSE, counter cleared, `coin`=1. PULSE: counter reaches COIN_PULSE-1 → HOLD (`coin`=0) if raw still high, else IDLE. HOLD → IDLE when raw low. Raw edges during PULSE ignored; no retrigger without release.

## Timing
- Reset: all outputs 0, all key latches 0, FSMs IDLE, counters 0, `old_tgl` loaded from `ps2_key[10]` (no spurious event on reset release).
- All outputs registered. Keyboard: latch updates on the edge seeing the toggle, output on the next edge (2-cycle latency). Joystick/rotate: 1-cycle latency.
- Coin high for exactly COIN_PULSE cycles. Autofire: fire high AUTOFIRE_DIV cycles, low AUTOFIRE_DIV cycles, first high cycle 1 cycle after raw fire rises.
- Simultaneous key event and joystick bit on same control: OR, no priority issue. Two ps2 events closer than 1 cycle are impossible by protocol; back-to-back toggles on consecutive cycles both processed.
- Reset mid-pulse or mid-autofire: outputs 0 on the following edge, FSMs IDLE; a held raw input after reset counts as a new rise.

## Test plan
- Toggle `ps2_key` with {1,1,0,75}: `up[0]`=1 two edges later; toggle {1,0,0,75}: `up[0]`=0 two edges later; key 2D → `up[1]` only.
- rotate=1, `joy_in[3]`=1 (player 0 up): `right[0]`=1 after 1 edge, `up[0]`=0; rotate=0 → `up[0]`=1.
- COIN_PULSE=5: joy bit 7 held 20 cycles → `coin[0]` high exactly 5 cycles, then low until release; re-press → second 5-cycle pulse.
- coin_on_start=1, key 16 pressed → `start[0]`=1 and `coin[0]` 5-cycle pulse; coin_on_start=0 → no coin.
- AUTOFIRE_DIV=3, autofire_en[0]=1, fire held 14 cycles → pattern 1,1,1,0,0,0,1,1,1,…; release → 0 next edge; autofire_en=0 → steady 1.
- Assert `reset` during coin pulse cycle 2 with coin still held: `coin`=0 next edge; after release of reset, new 5-cycle pulse starts.
